// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB with per-state strobes.
// Define MC_CTRL_BEQ_EN to make beq legal and drive the Branch strobe from its EXEC state.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          Opcode,
  input  logic                stall,
  output logic                PC_w,
  output logic                IR_w,
  output logic                I_or_D,
  output logic                Mem_r,
  output logic                Mem_w,
  output logic                Reg_w,
  output logic                Reg_dst,
  output logic                ALU_src,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                Branch,
  output logic                illegal,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int unsigned    WW        = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(MEM_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_BEQ_EN
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [1:0] ALU_SUB  = 2'b00;
`endif
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [5:0]       opc_q, opc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_last;
  logic             bad_state;
  logic             retire;
  logic [1:0]       alu_code;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDIU, OP_ORI, OP_LW, OP_SW: is_legal = 1'b1;
`ifdef MC_CTRL_BEQ_EN
      OP_BEQ:                                   is_legal = 1'b1;
`endif
      default:                                  is_legal = 1'b0;
    endcase
  endfunction

  assign wait_last = (wait_q == WAIT_LAST);
  assign bad_state = (state_q > S_WB);

  // Recovery from an unused encoding ignores stall so a corrupted state cannot persist.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    opc_d   = opc_q;
    retire  = 1'b0;
    if (bad_state) begin
      state_d = S_FETCH;
      wait_d  = '0;
    end else if (!stall) begin
      case (state_q)
        S_FETCH: begin
          if (wait_last) begin
            state_d = S_DECODE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_DECODE: begin
          opc_d   = Opcode;
          state_d = is_legal(Opcode) ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          case (opc_q)
            OP_LW, OP_SW: state_d = S_MEM;
`ifdef MC_CTRL_BEQ_EN
            OP_BEQ: begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
`endif
            default:      state_d = S_WB;
          endcase
        end
        S_MEM: begin
          if (wait_last) begin
            wait_d = '0;
            if (opc_q == OP_SW) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end else begin
              state_d = S_WB;
            end
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_WB: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU controls derive from the latched opcode alone, so they stay put from EXEC to WB.
  always_comb begin
    PC_w     = 1'b0;
    IR_w     = 1'b0;
    I_or_D   = 1'b0;
    Mem_r    = 1'b0;
    Mem_w    = 1'b0;
    Reg_w    = 1'b0;
    Reg_dst  = 1'b0;
    ALU_src  = 1'b0;
    Branch   = 1'b0;
    illegal  = 1'b0;
    alu_code = 2'b00;
    case (state_q)
      S_FETCH: begin
        Mem_r = 1'b1;
        IR_w  = wait_last;
        PC_w  = wait_last;
      end
      S_DECODE: illegal = !is_legal(Opcode);
      S_EXEC, S_MEM, S_WB: begin
        case (opc_q)
          OP_RTYPE: begin
            alu_code = ALU_FUNCT;
            Reg_dst  = 1'b1;
          end
          OP_ORI: begin
            alu_code = ALU_OR;
            ALU_src  = 1'b1;
          end
`ifdef MC_CTRL_BEQ_EN
          OP_BEQ: begin
            alu_code = ALU_SUB;
            Branch   = (state_q == S_EXEC);
          end
`endif
          default: begin
            alu_code = ALU_ADD;
            ALU_src  = 1'b1;
          end
        endcase
        if (state_q == S_MEM) begin
          I_or_D = 1'b1;
          Mem_r  = (opc_q == OP_LW);
          Mem_w  = (opc_q == OP_SW);
        end
        if (state_q == S_WB) Reg_w = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (stall || !rst_n) begin
      PC_w  = 1'b0;
      IR_w  = 1'b0;
      Mem_w = 1'b0;
      Reg_w = 1'b0;
    end
  end

  assign ALU_op    = ALU_OP_W'(alu_code);
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected-cycle queue model,
// randomized opcodes/stalls, plus directed literal checks.
`timescale 1ns/1ps
module tb_multicycle_control;
  localparam int unsigned MW = 1;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned VW = 13 + AW;
  localparam logic [VW-1:0] RESET_VEC = {3'd0, 4'b0001, 4'b0000, {AW{1'b0}}, 2'b00};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    Opcode;
  logic          stall;
  logic          PC_w, IR_w, I_or_D, Mem_r, Mem_w, Reg_w, Reg_dst, ALU_src, Branch, illegal;
  logic [AW-1:0] ALU_op;
  logic [2:0]    state;
  logic [CW-1:0] instr_cnt;

  multicycle_control #(.MEM_WAIT(MW), .ALU_OP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .stall(stall),
    .PC_w(PC_w), .IR_w(IR_w), .I_or_D(I_or_D), .Mem_r(Mem_r), .Mem_w(Mem_w),
    .Reg_w(Reg_w), .Reg_dst(Reg_dst), .ALU_src(ALU_src), .ALU_op(ALU_op),
    .Branch(Branch), .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, iord, memr, memw, regw, regdst, alusrc;
    logic [1:0] aluop;
    logic br, ill, retire;
  } rec_t;

  rec_t          q[$];
  logic [5:0]    forced[$];
  logic [5:0]    cur_op;
  int unsigned   model_cnt;
  logic          pending_pop;
  logic [VW-1:0] exp_vec;
  logic [CW-1:0] exp_cnt;
  logic          check_en;
  int unsigned   lit_sel;
  logic [31:0]   lit_exp;
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [VW-1:0] act_vec;

  assign act_vec = {state, PC_w, IR_w, I_or_D, Mem_r, Mem_w, Reg_w, Reg_dst, ALU_src,
                    ALU_op, Branch, illegal};

  function automatic logic legal_op(input logic [5:0] op);
`ifdef MC_CTRL_BEQ_EN
    return op == 6'd0 || op == 6'd9 || op == 6'd13 || op == 6'd35 || op == 6'd43 || op == 6'd4;
`else
    return op == 6'd0 || op == 6'd9 || op == 6'd13 || op == 6'd35 || op == 6'd43;
`endif
  endfunction

  function automatic logic [VW-1:0] pack(input rec_t r, input logic gate);
    return {r.st, r.pcw & ~gate, r.irw & ~gate, r.iord, r.memr, r.memw & ~gate,
            r.regw & ~gate, r.regdst, r.alusrc, AW'(r.aluop), r.br, r.ill};
  endfunction

  // Expected cycle list of one instruction, straight from the per-state rules.
  task automatic build(input logic [5:0] op);
    rec_t r;
    logic is_r, is_ld, is_st, is_br;
    cur_op = op;
    for (int unsigned i = 0; i <= MW; i++) begin
      r = '0; r.memr = 1'b1; r.pcw = (i == MW); r.irw = (i == MW);
      q.push_back(r);
    end
    r = '0; r.st = 3'd1; r.ill = !legal_op(op);
    q.push_back(r);
    if (!legal_op(op)) return;
    is_r = (op == 6'd0); is_ld = (op == 6'd35); is_st = (op == 6'd43); is_br = (op == 6'd4);
    r = '0; r.st = 3'd2;
    r.aluop  = is_r ? 2'b10 : (op == 6'd13) ? 2'b11 : is_br ? 2'b00 : 2'b01;
    r.alusrc = !(is_r || is_br);
    r.regdst = is_r;
    r.br = is_br; r.retire = is_br;
    q.push_back(r);
    if (is_br) return;
    if (is_ld || is_st) begin
      for (int unsigned i = 0; i <= MW; i++) begin
        r.st = 3'd3; r.iord = 1'b1; r.memr = is_ld; r.memw = is_st;
        r.retire = is_st && (i == MW);
        q.push_back(r);
      end
    end
    if (!is_st) begin
      r.st = 3'd4; r.iord = 1'b0; r.memr = 1'b0; r.memw = 1'b0; r.regw = 1'b1; r.retire = 1'b1;
      q.push_back(r);
    end
  endtask

  task automatic next_op(output logic [5:0] op);
    if (forced.size() != 0) begin
      op = forced.pop_front();
    end else begin
      case ($urandom_range(0, 7))
        0: op = 6'd0;
        1: op = 6'd9;
        2: op = 6'd13;
        3: op = 6'd35;
        4: op = 6'd43;
        5: op = 6'd4;
        6: op = 6'd63;
        default: op = 6'($urandom);
      endcase
    end
  endtask

  task automatic setup(input logic st_v);
    rec_t r;
    logic [5:0] op;
    if (pending_pop) begin
      r = q.pop_front();
      if (r.retire) model_cnt++;
    end
    if (q.size() == 0) begin
      next_op(op);
      build(op);
    end
    stall   = st_v;
    Opcode  = (q[0].st == 3'd1) ? cur_op : 6'($urandom);
    exp_vec = pack(q[0], st_v);
    exp_cnt = CW'(model_cnt);
    pending_pop = !st_v;
  endtask

  task automatic tick(input logic st_v);
    @(posedge clk); #1;
    lit_sel = 0;
    setup(st_v);
  endtask

  task automatic lit(input int unsigned sel, input logic [31:0] e);
    lit_sel = sel;
    lit_exp = e;
  endtask

  always @(negedge clk) begin
    logic [31:0] la;
    if (check_en) begin
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%b required=%b", $time, act_vec, exp_vec);
      end
      checks++;
      if (instr_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL instr_cnt t=%0t actual=%0d required=%0d", $time, instr_cnt, exp_cnt);
      end
      if (lit_sel != 0) begin
        case (lit_sel)
          1: la = 32'({Reg_w, Reg_dst, ALU_op});
          2: la = 32'(state);
          3: la = 32'(instr_cnt);
          4: la = 32'(illegal);
          5: la = 32'({Mem_r, I_or_D, Mem_w});
          6: la = 32'(Branch);
          default: la = '1;
        endcase
        checks++;
        if (la !== lit_exp) begin
          errors++;
          $display("FAIL literal%0d t=%0t actual=%0h required=%0h", lit_sel, $time, la, lit_exp);
        end
      end
    end
  end

  initial begin
    logic found;
    stall = 1'b0; Opcode = '0; rst_n = 1'b1; check_en = 1'b0; pending_pop = 1'b0;
    model_cnt = 0; lit_sel = 0; lit_exp = '0; exp_vec = RESET_VEC; exp_cnt = '0;
    #1 rst_n = 1'b0;
    check_en = 1'b1;
    lit(2, 0);
    repeat (2) @(posedge clk);
    forced.push_back(6'd0);
    forced.push_back(6'd35);
    forced.push_back(6'd43);
    forced.push_back(6'd63);
    forced.push_back(6'd35);
    @(posedge clk); #1;
    lit_sel = 0; rst_n = 1'b1;
    setup(1'b0);                              // cycle 1: R-type FETCH
    repeat (3) tick(1'b0);
    tick(1'b0); lit(1, 32'b11010);            // 5: R WB
    tick(1'b0); lit(3, 1);                    // 6: lw FETCH
    repeat (3) tick(1'b0);
    tick(1'b0); lit(5, 32'b110);              // 10: lw MEM
    tick(1'b0); lit(5, 32'b110);              // 11
    tick(1'b0); lit(1, 32'b10001);            // 12: lw WB
    tick(1'b0); lit(3, 2);                    // 13: sw FETCH
    repeat (3) tick(1'b0);
    tick(1'b0); lit(5, 32'b011);              // 17: sw MEM
    tick(1'b0);
    tick(1'b0); lit(3, 3);                    // 19: illegal FETCH
    tick(1'b0);
    tick(1'b0); lit(4, 1);                    // 21: illegal DECODE
    tick(1'b0); lit(3, 3);                    // 22: lw FETCH
    repeat (4) tick(1'b0);                    // 23..26
    tick(1'b1); lit(5, 32'b110);              // 27: stalled MEM
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);                               // 30
    tick(1'b0); lit(2, 4);                    // 31: WB three cycles late
    tick(1'b0); lit(3, 4);                    // 32

    for (int unsigned n = 0; n < 1500; n++) tick($urandom_range(0, 5) == 0);

    found = 1'b0;
    for (int unsigned n = 0; n < 100 && !found; n++) begin
      tick(1'b0);
      if (q[0].st == 3'd4) found = 1'b1;
    end
    if (!found) lit(8, 0);
    #2 rst_n = 1'b0;
    q.delete(); model_cnt = 0; pending_pop = 1'b0; stall = 1'b0;
    exp_vec = RESET_VEC; exp_cnt = '0;
    if (found) lit(2, 0);
    forced.push_back(6'd4);
    @(posedge clk); #1;
    lit_sel = 0; rst_n = 1'b1;
    setup(1'b0);                              // cycle 1: beq FETCH
    tick(1'b0);
    tick(1'b0);                               // 3: DECODE
`ifdef MC_CTRL_BEQ_EN
    tick(1'b0); lit(6, 1);                    // 4: EXEC
    tick(1'b0); lit(3, 1);
`else
    lit(4, 1);
    tick(1'b0); lit(3, 0);
`endif
    for (int unsigned n = 0; n < 300; n++) tick($urandom_range(0, 4) == 0);

    @(negedge clk); #1;
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
